// File: rtl/fpu_minmax_reduce_if.sv
// Command, element-stream and result signals of the min/max reduction sequencer.
// The master side issues commands and elements; the slave side is the sequencer.
interface fpu_minmax_reduce_if #(
   parameter int CNT_W = 8
);
   logic             start_i;
   logic             mode_i;
   logic [CNT_W-1:0] len_i;
   logic             abort_i;
   logic             busy_o;
   logic             in_valid_i;
   logic [15:0]      in_data_i;
   logic             in_ready_o;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [15:0]      out_data_o;
   logic [CNT_W-1:0] out_idx_o;

   modport master (
      output start_i, mode_i, len_i, abort_i, in_valid_i, in_data_i, out_ready_i,
      input  busy_o, in_ready_o, out_valid_o, out_data_o, out_idx_o
   );

   modport slave (
      input  start_i, mode_i, len_i, abort_i, in_valid_i, in_data_i, out_ready_i,
      output busy_o, in_ready_o, out_valid_o, out_data_o, out_idx_o
   );
endinterface

// File: rtl/fpu_minmax_reduce.sv
// Streams bf16 elements through one sign-magnitude MinMax comparator and returns
// the running max/min together with the index of its first occurrence.

module fpu_minmax_cmp (
   input  logic        i_mode,
   input  logic [15:0] i_rs1,
   input  logic [15:0] i_rs2,
   output logic [15:0] o_res
);
   logic w_rs1_lt_rs2;
   logic w_rs2_lt_rs1;

   // Sign-magnitude "less than": -0 sorts below +0, NaN/Inf are plain bit patterns.
   function automatic logic sm_lt(input logic [15:0] a, input logic [15:0] b);
      if (a[15] != b[15]) begin
         return a[15];
      end else if (a[15]) begin
         return a[14:0] > b[14:0];
      end else begin
         return a[14:0] < b[14:0];
      end
   endfunction

   assign w_rs1_lt_rs2 = sm_lt(i_rs1, i_rs2);
   assign w_rs2_lt_rs1 = sm_lt(i_rs2, i_rs1);

   // Ties keep rs1, so the accumulator never moves on an equal element.
   always_comb begin
      o_res = i_rs1;
      if (i_mode) begin
         if (w_rs2_lt_rs1) o_res = i_rs2;
      end else begin
         if (w_rs1_lt_rs2) o_res = i_rs2;
      end
   end
endmodule

module fpu_minmax_reduce #(
   parameter int CNT_W = 8
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   fpu_minmax_reduce_if.slave  mm
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FIRST = 2'd1,
      S_ACCUM = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic             r_mode;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_cnt;
   logic [15:0]      r_acc;
   logic [CNT_W-1:0] r_idx;

   state_t           w_state_next;
   logic             w_mode_next;
   logic [CNT_W-1:0] w_len_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic [15:0]      w_acc_next;
   logic [CNT_W-1:0] w_idx_next;

   logic             w_in_ready;
   logic             w_hs;
   logic [15:0]      w_cmp;
   logic             w_improves;
   logic             w_last;

   fpu_minmax_cmp u_minmax (
      .i_mode (r_mode),
      .i_rs1  (r_acc),
      .i_rs2  (mm.in_data_i),
      .o_res  (w_cmp)
   );

   assign w_in_ready = (r_state == S_FIRST) || (r_state == S_ACCUM);
   assign w_hs       = mm.in_valid_i && w_in_ready;
   // Only a strict improvement moves acc/idx, which keeps the first occurrence.
   assign w_improves = (w_cmp == mm.in_data_i) && (mm.in_data_i != r_acc);
   assign w_last     = (r_cnt == (r_len - CNT_W'(1)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_mode  <= 1'b0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_next;
         r_mode  <= w_mode_next;
         r_len   <= w_len_next;
         r_cnt   <= w_cnt_next;
         r_acc   <= w_acc_next;
         r_idx   <= w_idx_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_mode_next  = r_mode;
      w_len_next   = r_len;
      w_cnt_next   = r_cnt;
      w_acc_next   = r_acc;
      w_idx_next   = r_idx;

      case (r_state)
         S_IDLE: begin
            if (mm.start_i) begin
               if (mm.len_i != '0) begin
                  w_mode_next  = mm.mode_i;
                  w_len_next   = mm.len_i;
                  w_cnt_next   = '0;
                  w_state_next = S_FIRST;
               end else begin
                  w_acc_next   = 16'h0000;
                  w_idx_next   = '0;
                  w_state_next = S_DONE;
               end
            end
         end
         S_FIRST: begin
            if (w_hs) begin
               w_acc_next   = mm.in_data_i;
               w_idx_next   = '0;
               w_cnt_next   = CNT_W'(1);
               w_state_next = (r_len == CNT_W'(1)) ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (w_hs) begin
               w_cnt_next = r_cnt + CNT_W'(1);
               if (w_improves) begin
                  w_acc_next = w_cmp;
                  w_idx_next = r_cnt;
               end
               if (w_last) w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (mm.out_ready_i) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase

      // Abort wins over a same-cycle handshake: the element is dropped unseen.
      if (mm.abort_i && (r_state != S_IDLE)) begin
         w_state_next = S_IDLE;
         w_cnt_next   = r_cnt;
         w_acc_next   = r_acc;
         w_idx_next   = r_idx;
      end
   end

   assign mm.busy_o      = (r_state != S_IDLE);
   assign mm.in_ready_o  = w_in_ready;
   assign mm.out_valid_o = (r_state == S_DONE);
   assign mm.out_data_o  = (r_state == S_DONE) ? r_acc : 16'h0000;
   assign mm.out_idx_o   = (r_state == S_DONE) ? r_idx : '0;
endmodule

// File: tb/tb_fpu_minmax_reduce.sv
// Directed bench for fpu_minmax_reduce: hand-computed results for max/min,
// ties, length boundaries, stalls, abort and asynchronous reset.
module tb_fpu_minmax_reduce;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [15:0] vec [0:255];

   fpu_minmax_reduce_if #(.CNT_W(8)) mm ();

   fpu_minmax_reduce #(.CNT_W(8)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .mm     (mm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one command up to the cycle where out_valid_o is seen; lat counts
   // edges from the start edge (inclusive) to the first valid cycle.
   task automatic run_vec(input logic m, input int n, input bit gaps,
                          input bit poke_start, output int lat);
      int k;
      bit hs;
      @(negedge clk);
      mm.start_i = 1'b1;
      mm.mode_i  = m;
      mm.len_i   = 8'(n);
      @(posedge clk); #1;
      mm.start_i = 1'b0;
      lat = 1;
      k = 0;
      while (!mm.out_valid_o && lat < 1000) begin
         if (k < n && (!gaps || $urandom_range(0, 2) != 0)) begin
            mm.in_valid_i = 1'b1;
            mm.in_data_i  = vec[k];
         end else begin
            mm.in_valid_i = 1'b0;
            mm.in_data_i  = 16'hDEAD;
         end
         if (poke_start) begin
            mm.start_i = 1'($urandom_range(0, 1));
            mm.mode_i  = ~m;
            mm.len_i   = 8'd1;
         end
         hs = mm.in_valid_i && mm.in_ready_o;
         @(posedge clk); #1;
         if (hs) k++;
         lat++;
      end
      mm.in_valid_i = 1'b0;
      mm.start_i    = 1'b0;
      mm.mode_i     = m;
      total++;
      if (mm.out_valid_o !== 1'b1) begin
         bad++;
         $display("FAIL run_timeout: out_valid=%b after %0d cycles, required 1", mm.out_valid_o, lat);
      end
   endtask

   task automatic pop_result(output logic [15:0] d, output logic [7:0] ix,
                             output logic busy_after, output logic valid_after);
      d  = mm.out_data_o;
      ix = mm.out_idx_o;
      mm.out_ready_i = 1'b1;
      @(posedge clk); #1;
      mm.out_ready_i = 1'b0;
      busy_after  = mm.busy_o;
      valid_after = mm.out_valid_o;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      total++;
      if ({mm.busy_o, mm.in_ready_o, mm.out_valid_o, mm.out_data_o, mm.out_idx_o} !== 27'd0) begin
         bad++;
         $display("FAIL reset_outputs: busy=%b rdy=%b vld=%b data=%h idx=%0d, required all 0",
                  mm.busy_o, mm.in_ready_o, mm.out_valid_o, mm.out_data_o, mm.out_idx_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (mm.busy_o !== 1'b0 || mm.out_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: busy=%b vld=%b, required 0 0", mm.busy_o, mm.out_valid_o);
      end
   endtask

   task automatic test_max_basic;
      int lat;
      logic [15:0] d; logic [7:0] ix; logic b, v;
      vec[0] = 16'h3F80; vec[1] = 16'hBF80; vec[2] = 16'h4000; vec[3] = 16'h3F80;
      run_vec(1'b0, 4, 1'b0, 1'b0, lat);
      total++;
      if (lat !== 5) begin bad++; $display("FAIL max_latency: got %0d required 5", lat); end
      pop_result(d, ix, b, v);
      total++;
      if (d !== 16'h4000 || ix !== 8'd2) begin
         bad++; $display("FAIL max_basic: got %h/%0d required 4000/2", d, ix);
      end
      total++;
      if (b !== 1'b0 || v !== 1'b0) begin
         bad++; $display("FAIL max_to_idle: busy=%b vld=%b required 0 0", b, v);
      end
      $display("max basic: data=%h idx=%0d lat=%0d", d, ix, lat);
   endtask

   task automatic test_min_signed;
      int lat;
      logic [15:0] d; logic [7:0] ix; logic b, v;
      vec[0] = 16'h0000; vec[1] = 16'h8000; vec[2] = 16'h3F80;
      run_vec(1'b1, 3, 1'b0, 1'b0, lat);
      pop_result(d, ix, b, v);
      total++;
      if (d !== 16'h8000 || ix !== 8'd1 || lat !== 4) begin
         bad++; $display("FAIL min_signed: got %h/%0d lat %0d required 8000/1 lat 4", d, ix, lat);
      end
      $display("min signed: data=%h idx=%0d", d, ix);
      run_vec(1'b0, 3, 1'b0, 1'b0, lat);
      pop_result(d, ix, b, v);
      total++;
      if (d !== 16'h3F80 || ix !== 8'd2) begin
         bad++; $display("FAIL max_signed: got %h/%0d required 3f80/2", d, ix);
      end
      $display("max signed: data=%h idx=%0d", d, ix);
   endtask

   task automatic test_ties;
      int lat;
      logic [15:0] d; logic [7:0] ix; logic b, v;
      vec[0] = 16'h4000; vec[1] = 16'h3F80; vec[2] = 16'h4000; vec[3] = 16'h4000;
      run_vec(1'b0, 4, 1'b0, 1'b0, lat);
      pop_result(d, ix, b, v);
      total++;
      if (d !== 16'h4000 || ix !== 8'd0) begin
         bad++; $display("FAIL tie_max: got %h/%0d required 4000/0", d, ix);
      end
      $display("tie max: data=%h idx=%0d", d, ix);
      vec[0] = 16'hC000; vec[1] = 16'hC000; vec[2] = 16'hC000;
      run_vec(1'b1, 3, 1'b0, 1'b0, lat);
      pop_result(d, ix, b, v);
      total++;
      if (d !== 16'hC000 || ix !== 8'd0) begin
         bad++; $display("FAIL tie_min: got %h/%0d required c000/0", d, ix);
      end
      $display("tie min: data=%h idx=%0d", d, ix);
   endtask

   task automatic test_boundaries;
      int lat;
      logic [15:0] d; logic [7:0] ix; logic b, v;
      run_vec(1'b0, 0, 1'b0, 1'b0, lat);
      pop_result(d, ix, b, v);
      total++;
      if (d !== 16'h0000 || ix !== 8'd0 || lat !== 1) begin
         bad++; $display("FAIL len0: got %h/%0d lat %0d required 0000/0 lat 1", d, ix, lat);
      end
      $display("len0: data=%h idx=%0d lat=%0d", d, ix, lat);
      vec[0] = 16'hBF80;
      run_vec(1'b0, 1, 1'b0, 1'b0, lat);
      pop_result(d, ix, b, v);
      total++;
      if (d !== 16'hBF80 || ix !== 8'd0 || lat !== 2) begin
         bad++; $display("FAIL len1: got %h/%0d lat %0d required bf80/0 lat 2", d, ix, lat);
      end
      $display("len1: data=%h idx=%0d lat=%0d", d, ix, lat);
      for (int k = 0; k < 256; k++) begin
         vec[k] = (k % 2 == 1) ? (16'hC000 | 16'(k)) : (16'h0100 + 16'(k));
      end
      vec[254] = 16'h7000;
      run_vec(1'b0, 255, 1'b0, 1'b0, lat);
      pop_result(d, ix, b, v);
      total++;
      if (d !== 16'h7000 || ix !== 8'd254 || lat !== 256) begin
         bad++; $display("FAIL len255: got %h/%0d lat %0d required 7000/254 lat 256", d, ix, lat);
      end
      $display("len255: data=%h idx=%0d lat=%0d", d, ix, lat);
   endtask

   task automatic test_stalls;
      int lat;
      logic [15:0] d; logic [7:0] ix; logic b, v;
      vec[0] = 16'h3F80; vec[1] = 16'hBF80; vec[2] = 16'h4000; vec[3] = 16'h3F80;
      run_vec(1'b0, 4, 1'b1, 1'b1, lat);
      for (int c = 0; c < 5; c++) begin
         total++;
         if (mm.out_valid_o !== 1'b1 || mm.out_data_o !== 16'h4000 || mm.out_idx_o !== 8'd2) begin
            bad++;
            $display("FAIL stall_hold: cycle %0d vld=%b data=%h idx=%0d required 1/4000/2",
                     c, mm.out_valid_o, mm.out_data_o, mm.out_idx_o);
         end
         @(posedge clk); #1;
      end
      pop_result(d, ix, b, v);
      total++;
      if (d !== 16'h4000 || ix !== 8'd2 || b !== 1'b0) begin
         bad++; $display("FAIL stall_result: got %h/%0d busy %b required 4000/2 busy 0", d, ix, b);
      end
      $display("stalled: data=%h idx=%0d", d, ix);
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [15:0] d; logic [7:0] ix; logic b, v;
      vec[0] = 16'h1111; vec[1] = 16'h2222;
      run_vec(1'b0, 2, 1'b0, 1'b0, lat);
      pop_result(d, ix, b, v);
      vec[0] = 16'h9111; vec[1] = 16'h0001;
      run_vec(1'b1, 2, 1'b0, 1'b0, lat);
      pop_result(d, ix, b, v);
      total++;
      if (d !== 16'h9111 || ix !== 8'd0 || lat !== 3) begin
         bad++; $display("FAIL back_to_back: got %h/%0d lat %0d required 9111/0 lat 3", d, ix, lat);
      end
      $display("back to back: data=%h idx=%0d lat=%0d", d, ix, lat);
   endtask

   task automatic test_abort;
      int lat;
      bit seen;
      logic [15:0] d; logic [7:0] ix; logic b, v;
      vec[0] = 16'h3F80; vec[1] = 16'hBF80;
      @(negedge clk);
      mm.start_i = 1'b1; mm.mode_i = 1'b0; mm.len_i = 8'd4;
      @(posedge clk); #1;
      mm.start_i = 1'b0;
      mm.in_valid_i = 1'b1; mm.in_data_i = vec[0];
      @(posedge clk); #1;
      mm.in_data_i = vec[1]; mm.abort_i = 1'b1;
      @(posedge clk); #1;
      mm.abort_i = 1'b0; mm.in_valid_i = 1'b0;
      total++;
      if (mm.busy_o !== 1'b0 || mm.in_ready_o !== 1'b0 || mm.out_valid_o !== 1'b0) begin
         bad++; $display("FAIL abort_idle: busy=%b rdy=%b vld=%b required 0 0 0",
                         mm.busy_o, mm.in_ready_o, mm.out_valid_o);
      end
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (mm.out_valid_o) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_valid: valid seen=1 required 0"); end
      $display("abort in accum: busy=%b", mm.busy_o);
      vec[0] = 16'hBF80; vec[1] = 16'h3F80;
      run_vec(1'b0, 2, 1'b0, 1'b0, lat);
      pop_result(d, ix, b, v);
      total++;
      if (d !== 16'h3F80 || ix !== 8'd1 || lat !== 3) begin
         bad++; $display("FAIL after_abort: got %h/%0d lat %0d required 3f80/1 lat 3", d, ix, lat);
      end
      $display("after abort: data=%h idx=%0d", d, ix);
      // Pending result in DONE is dropped by abort.
      vec[0] = 16'h5555;
      run_vec(1'b0, 1, 1'b0, 1'b0, lat);
      mm.abort_i = 1'b1;
      @(posedge clk); #1;
      mm.abort_i = 1'b0;
      total++;
      if (mm.out_valid_o !== 1'b0 || mm.busy_o !== 1'b0) begin
         bad++; $display("FAIL abort_done: vld=%b busy=%b required 0 0", mm.out_valid_o, mm.busy_o);
      end
      $display("abort in done: vld=%b", mm.out_valid_o);
   endtask

   task automatic test_reset_mid;
      int lat;
      logic [15:0] d; logic [7:0] ix; logic b, v;
      vec[0] = 16'h3F80; vec[1] = 16'h4000;
      @(negedge clk);
      mm.start_i = 1'b1; mm.mode_i = 1'b0; mm.len_i = 8'd4;
      @(posedge clk); #1;
      mm.start_i = 1'b0;
      mm.in_valid_i = 1'b1; mm.in_data_i = vec[0];
      @(posedge clk); #1;
      mm.in_data_i = vec[1];
      @(posedge clk); #1;
      mm.in_valid_i = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({mm.busy_o, mm.in_ready_o, mm.out_valid_o, mm.out_data_o, mm.out_idx_o} !== 27'd0) begin
         bad++;
         $display("FAIL reset_mid: busy=%b rdy=%b vld=%b data=%h idx=%0d, required all 0",
                  mm.busy_o, mm.in_ready_o, mm.out_valid_o, mm.out_data_o, mm.out_idx_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (mm.busy_o !== 1'b0 || mm.out_valid_o !== 1'b0) begin
         bad++; $display("FAIL reset_mid_release: busy=%b vld=%b required 0 0", mm.busy_o, mm.out_valid_o);
      end
      vec[0] = 16'h1234;
      run_vec(1'b0, 1, 1'b0, 1'b0, lat);
      pop_result(d, ix, b, v);
      total++;
      if (d !== 16'h1234 || ix !== 8'd0) begin
         bad++; $display("FAIL after_reset: got %h/%0d required 1234/0", d, ix);
      end
      $display("after reset: data=%h idx=%0d", d, ix);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      mm.start_i     = 1'b0;
      mm.mode_i      = 1'b0;
      mm.len_i       = 8'd0;
      mm.abort_i     = 1'b0;
      mm.in_valid_i  = 1'b0;
      mm.in_data_i   = 16'h0000;
      mm.out_ready_i = 1'b0;
      for (int k = 0; k < 256; k++) vec[k] = 16'h0000;
      test_reset();
      test_max_basic();
      test_min_signed();
      test_ties();
      test_boundaries();
      test_stalls();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fpu_minmax_reduce.md
# fpu_minmax_reduce

Sequencer that streams a vector of 16-bit sign-magnitude (bf16) elements through one instance of the FPU's `MinMax` comparator and returns the running maximum or minimum plus the index of its first occurrence. It sits beside the FPU datapath. It takes a start command with a length, accepts elements over a valid/ready stream, and presents one result over a valid/ready output. A single accumulator register and a single comparator are reused for every element.

## Interface
- `CNT_W`, default 8: width of the length, counter and index fields. The maximum vector length is 2^CNT_W − 1.
- `clk_i` input 1: clock. All state updates on the rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `start_i` input 1: command strobe. Sampled only in IDLE.
- `mode_i` input 1: 0 = maximum, 1 = minimum. Latched on an accepted start.
- `len_i` input CNT_W: number of elements. Latched on an accepted start.
- `abort_i` input 1: cancels any operation in progress.
- `busy_o` output 1: high in every state except IDLE.
- `in_valid_i` input 1: element valid.
- `in_data_i` input 16: element value.
- `in_ready_o` output 1: element accepted when both `in_valid_i` and `in_ready_o` are high.
- `out_valid_o` output 1: result valid.
- `out_ready_i` input 1: result consumer ready.
- `out_data_o` output 16: reduced value.
- `out_idx_o` output CNT_W: zero-based index of the first element equal to the result.

## Operation
- **Comparator.** One `MinMax` instance with rs1 = acc, rs2 = `in_data_i` and mode = latched mode.
  - Effective ordering is sign-magnitude.
  - Negatives order below positives, and 0x8000 (−0) orders below 0x0000 (+0).
  - Larger magnitude is larger when positive and smaller when negative.
  - NaN and Inf patterns get no special handling; they are ordered by bit pattern.
- **States.** IDLE, FIRST, ACCUM, DONE.
- **IDLE:**
  - `start_i`=1 with `len_i`≠0: latch mode and len, clear cnt, go to FIRST.
  - `start_i`=1 with `len_i`=0: set acc=0x0000 and idx=0, go to DONE.
- **FIRST:** on handshake, acc←`in_data_i`, idx←0, cnt←1.
  - If len=1, go to DONE; otherwise go to ACCUM.
- **ACCUM:** on handshake, cnt←cnt+1.
  - Replace acc with the comparator output, and set idx←cnt, only when the comparator output equals `in_data_i` and `in_data_i`≠acc. This is a strict improvement, so the first occurrence wins.
  - When the accepted element is element len−1 (cnt = len−1 before the increment), go to DONE.
- **DONE:** `out_valid_o`=1 with `out_data_o`=acc and `out_idx_o`=idx, held stable until `out_ready_i`=1. Then go to IDLE.
- **Output gating.** `in_ready_o`=1 only in FIRST and ACCUM.
- **Abort.** `abort_i`=1 in any non-IDLE state forces IDLE on the next edge.
  - `out_valid_o` is not raised, and a pending result is dropped.
  - Abort has priority over a simultaneous handshake in the same cycle; that element is discarded.
- **Start while busy.** `start_i` outside IDLE is ignored, and `len_i`/`mode_i` changes are ignored.
- **Reset.** State=IDLE; acc, idx and cnt=0. All outputs are 0: `busy_o`, `in_ready_o`, `out_valid_o`, `out_data_o`, `out_idx_o`.
  - Reset asserted mid-operation discards everything.
  - No result is produced after reset is released.

## Timing
- Throughput is one element per cycle while `in_valid_i` is held high. The comparator is combinational, and acc/idx update on the same edge as the handshake.
- Start accepted at edge T: `in_ready_o` is high from T.
- Last element accepted at edge E: `out_valid_o` is high from E, i.e. in the cycle after the last handshake.
- For len=N with no stalls, the latency from start edge to `out_valid_o` is N+1 cycles.
- len=0: `out_valid_o` is high one cycle after the start edge.
- The result handshake at edge R returns to IDLE at R, so a new start can be accepted at edge R+1.
- A start is never accepted in the same cycle as a result handshake.
- Input stalls (`in_valid_i`=0) insert idle cycles; state, cnt and acc hold.
- Output stalls (`out_ready_i`=0) hold all outputs bit-stable.

## Test plan
- **Max, basic.** Start mode=0, len=4, data 0x3F80, 0xBF80, 0x4000, 0x3F80 → out 0x4000, idx 2, `out_valid_o` 5 cycles after start.
- **Min, signed ordering.** Mode=1, len=3, data 0x0000, 0x8000, 0x3F80 → out 0x8000, idx 1. The same vector with mode=0 → out 0x3F80, idx 2.
- **Ties and first occurrence.** Mode=0, len=4, data 0x4000, 0x3F80, 0x4000, 0x4000 → idx 0. Mode=1 on all-equal 0xC000 ×3 → out 0xC000, idx 0.
- **Boundaries.** len=0 → out 0x0000, idx 0, valid 1 cycle after start. len=1 with 0xBF80 → out 0xBF80, idx 0. len=255 ramp with the max at element 254 → idx 254.
- **Stalls.** Random `in_valid_i` gaps and `out_ready_i` held low for 5 cycles → result identical to the unstalled run. Outputs remain stable while stalled, and `start_i` pulses during busy are ignored.
- **Abort and reset.** Abort during ACCUM at the 2nd element → IDLE next cycle, no `out_valid_o`, and a following len=2 run is correct. `rst_ni` low mid-run → all outputs 0 immediately, IDLE after release.
